// File: rtl/mem_access_pkg.sv
// Shared encodings and reset defaults for the memory-access arbiter.
package mem_access_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHK_LO = 3'd1;
    localparam logic [2:0] ST_CHK_HI = 3'd2;
    localparam logic [2:0] ST_GRANT  = 3'd3;
    localparam logic [2:0] ST_DENY   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        CHK_LO = ST_CHK_LO,
        CHK_HI = ST_CHK_HI,
        GRANT  = ST_GRANT,
        DENY   = ST_DENY
    } state_e;

    localparam logic CFG_SEL_LO = 1'b0;
    localparam logic CFG_SEL_HI = 1'b1;

    localparam logic [3:0] DEFAULT_LO_C = 4'h0;
    localparam logic [3:0] DEFAULT_HI_C = 4'hF;

endpackage

// File: rtl/Comparator_4bit.sv
// Unsigned 4-bit magnitude comparator: C = A<B, D = A==B, E = A>B.
// Latency: purely combinational.
// Backpressure: none.
module Comparator_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       C,
    output logic       D,
    output logic       E
);

    assign C = (A <  B);
    assign D = (A == B);
    assign E = (A >  B);

endmodule

// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin arbiter that bounds-checks each address against [lo, hi].
// Latency: grant in the 3rd cycle after acceptance; low-bound deny in the 2nd, high-bound deny in the 3rd.
// Backpressure: requesters hold req until their grant/deny pulse; cfg writes while busy are dropped and flagged.
module mem_access_arbiter
    import mem_access_pkg::*;
#(
    parameter int                ADDR_W     = 4,
    parameter logic [ADDR_W-1:0] DEFAULT_LO = DEFAULT_LO_C,
    parameter logic [ADDR_W-1:0] DEFAULT_HI = DEFAULT_HI_C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [ADDR_W-1:0] cfg_data,
    output logic              cfg_err,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic [1:0]        grant,
    output logic [1:0]        deny,
    output logic              busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr
);

    state_e              state_q;
    logic                id_q;
    logic                rr_q;
    logic [ADDR_W-1:0]   a_q;
    logic [ADDR_W-1:0]   lo_q;
    logic [ADDR_W-1:0]   hi_q;
    logic [1:0]          grant_q;
    logic [1:0]          deny_q;
    logic                busy_q;
    logic                mem_en_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                cfg_err_q;

    logic                sel_id_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    logic [ADDR_W-1:0]   cmp_b;
    logic                cmp_lt;
    logic                cmp_eq_unused;
    logic                cmp_gt;

    // The pointer only matters when both requesters compete.
    always_comb begin
        sel_id_d = rr_q;
        if (req == 2'b01) begin
            sel_id_d = 1'b0;
        end else if (req == 2'b10) begin
            sel_id_d = 1'b1;
        end
        sel_addr_d = sel_id_d ? addr1 : addr0;
        cmp_b      = (state_q == CHK_HI) ? hi_q : lo_q;
    end

    Comparator_4bit u_cmp (
        .A (a_q),
        .B (cmp_b),
        .C (cmp_lt),
        .D (cmp_eq_unused),
        .E (cmp_gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            id_q       <= 1'b0;
            rr_q       <= 1'b0;
            a_q        <= '0;
            lo_q       <= DEFAULT_LO;
            hi_q       <= DEFAULT_HI;
            grant_q    <= 2'b00;
            deny_q     <= 2'b00;
            busy_q     <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            grant_q   <= 2'b00;
            deny_q    <= 2'b00;
            mem_en_q  <= 1'b0;
            cfg_err_q <= cfg_we && (state_q != IDLE);

            case (state_q)
                IDLE: begin
                    if (cfg_we) begin
                        if (cfg_sel == CFG_SEL_LO) begin
                            lo_q <= cfg_data;
                        end else begin
                            hi_q <= cfg_data;
                        end
                    end
                    if (|req) begin
                        id_q       <= sel_id_d;
                        a_q        <= sel_addr_d;
                        mem_addr_q <= sel_addr_d;
                        busy_q     <= 1'b1;
                        state_q    <= CHK_LO;
                    end
                end
                CHK_LO: begin
                    if (cmp_lt) begin
                        deny_q[id_q] <= 1'b1;
                        state_q      <= DENY;
                    end else begin
                        state_q <= CHK_HI;
                    end
                end
                CHK_HI: begin
                    if (cmp_gt) begin
                        deny_q[id_q] <= 1'b1;
                        state_q      <= DENY;
                    end else begin
                        grant_q[id_q] <= 1'b1;
                        mem_en_q      <= 1'b1;
                        state_q       <= GRANT;
                    end
                end
                GRANT, DENY: begin
                    rr_q    <= ~id_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign deny     = deny_q;
    assign busy     = busy_q;
    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Two-requester access controller for the memory-access path. Grants or denies each request after a bounds check of its 4-bit address against a programmable window [lo, hi].
- Uses the team's existing Comparator_4bit. One instance is time-multiplexed: a lower-bound check, then an upper-bound check.
- Arbitration between requesters is round-robin. On a grant it drives a one-cycle memory enable plus the address.

Parameters:
- ADDR_W, 4, address width. Fixed at 4 to match Comparator_4bit; any other value is unsupported.
- DEFAULT_LO, 4'h0, reset value of the lower-bound register.
- DEFAULT_HI, 4'hF, reset value of the upper-bound register.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  bound-register write strobe.
- cfg_sel  in  1  bound select: 0 = lo, 1 = hi.
- cfg_data  in  4  new bound value.
- cfg_err  out  1  one-cycle pulse when cfg_we arrives while busy; that write is dropped.
- req  in  2  level request per requester, held until its grant/deny.
- addr0  in  4  requester 0 address, valid while req[0].
- addr1  in  4  requester 1 address, valid while req[1].
- grant  out  2  one-hot, one-cycle pulse: access allowed.
- deny  out  2  one-hot, one-cycle pulse: access refused.
- busy  out  1  high whenever state != IDLE.
- mem_en  out  1  one-cycle enable, coincident with grant.
- mem_addr  out  4  latched address of the current or last transaction.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all outputs 0; lo=DEFAULT_LO, hi=DEFAULT_HI; rr_ptr=0.
  - Reset mid-transaction aborts it; no grant or deny pulse is issued.
- All outputs are registered.
- States: IDLE, CHK_LO, CHK_HI, GRANT, DENY.
- IDLE:
  - If any req bit is set: select requester id. With both requesting, id=rr_ptr; otherwise the single requester.
  - Latch id, the selected address into a_reg and mem_addr, and -> CHK_LO.
  - No request: stay in IDLE.
- CHK_LO: comparator A=a_reg, B=lo. If C (a_reg<lo) -> DENY, else -> CHK_HI.
- CHK_HI: comparator A=a_reg, B=hi. If E (a_reg>hi) -> DENY, else -> GRANT.
- GRANT: grant[id]=1, mem_en=1 for exactly one cycle; rr_ptr=~id; -> IDLE.
- DENY: deny[id]=1 for exactly one cycle; rr_ptr=~id; -> IDLE.
- Latency, counted from the IDLE edge that accepts the request:
  - Grant pulse is in the 3rd cycle after acceptance.
  - Deny on a failed lower-bound check comes 1 cycle earlier than a deny on a failed upper-bound check.
- Comparator muxing: B=lo in CHK_LO, B=hi in CHK_HI, B=lo otherwise (don't care).
- Handshake rules:
  - A requester must deassert req in the cycle after it sees its grant/deny; IDLE samples req in that cycle.
  - req dropped mid-check does not cancel the transaction; the result pulse is still issued for the latched id.
  - addr changes after acceptance are ignored.
- Config writes:
  - Accepted only in IDLE, effective next cycle.
  - cfg_we together with a request in IDLE: the write commits, and the new request is checked against the new value because CHK_LO/CHK_HI occur later.
  - cfg_we while busy: write dropped, cfg_err pulses next cycle.
- Boundaries:
  - Window is inclusive: addr==lo and addr==hi are both granted.
  - lo>hi denies every address. Not an error.
  - lo=0, hi=F grants every address.
- Fairness: with both requesters continuously active, service alternates 0,1,0,1,…

Decomposition:
- Shared package mem_access_pkg holds:
  - state encoding localparams (3-bit: IDLE=0, CHK_LO=1, CHK_HI=2, GRANT=3, DENY=4);
  - CFG_SEL_LO=0, CFG_SEL_HI=1;
  - default bound constants.
- One sub-module: a single instance of the existing Comparator_4bit (outputs C=A<B, D=A==B, E=A>B).
- Arbitration, FSM and bound registers stay inline.

Test Plan:
1. Reset defaults: after reset, req=01, addr0=7 -> grant=01 and mem_en=1 in the 3rd cycle after acceptance, mem_addr=7; busy high for 3 cycles. Reset values: all outputs 0, lo=0, hi=F.
2. Window edges: program lo=3, hi=9; addr0=3 -> grant; addr0=9 -> grant; addr0=2 -> deny at cycle 2 (low fail); addr0=A -> deny at cycle 3 (high fail).
3. Round-robin: req=11 held, addr0=4, addr1=5, each requester dropping req for 1 cycle after its response -> served in order 0,1,0,1; grant pulses never overlap; mem_addr alternates 4,5.
4. Config while busy: cfg_we=1, cfg_sel=1, cfg_data=2 during CHK_LO -> cfg_err pulses, hi unchanged (F), transaction granted. Repeating the same write in IDLE -> hi=2, and a following addr=5 is denied.
5. Empty window: lo=A, hi=5 -> addresses 0, 5, 7, A and F are all denied; no mem_en.
6. Async reset mid-check: assert rst_n=0 in CHK_HI -> outputs clear immediately, no grant/deny pulse, bounds back to defaults, next request served from IDLE with rr_ptr=0.
